staller: RTL
============

STALLER -- requirements
Module: staller

Interface
REQ-001 Parameter: TIMEOUT, default 255, consecutive memory-wait cycles after which err_o sets.
REQ-002 Parameter: CNT_W, default 32, width of stall_cnt_o.
REQ-003 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  in  1  reset; asynchronous and active-low.
REQ-005 Port: mem_req_MEM_i  in  1  MEM stage has a data-memory access outstanding.
REQ-006 Port: mem_done_i  in  1  data-memory access completes this cycle.
REQ-007 Port: jump_EX_i  in  1  taken branch/jump resolved in EX this cycle.
REQ-008 Port: ld_hazard_ID_i  in  1  load-use hazard detected between ID and EX.
REQ-009 Port: if_req_i  in  1  instruction fetch outstanding.
REQ-010 Port: if_done_i  in  1  instruction fetch completes this cycle.
REQ-011 Port: stl_PC_o, stl_IF_ID_o, stl_ID_EX_o, stl_EX_MEM_o, stl_MEM_WB_o  out  2 each  per-stage control: NORMAL=2'b00, STALL=2'b01, BUBBLE=2'b10.
REQ-012 Port: stall_cnt_o  out  CNT_W  cycles in which stl_PC_o != NORMAL; saturating.
REQ-013 Port: err_o  out  1  sticky memory-wait timeout flag.

Function
REQ-014 Derived terms: mem_stall = mem_req_MEM_i & ~mem_done_i; if_stall = if_req_i & ~if_done_i.
REQ-015 Stage controls are combinational from the current inputs and the state; zero-cycle latency.
REQ-016 FSM states: RUN, DISCARD. DISCARD marks an in-flight fetch on the wrong path.
REQ-017 Priority 1, mem_stall: PC, IF_ID, ID_EX and EX_MEM = STALL; MEM_WB = BUBBLE; the FSM state is unchanged.
REQ-018 Priority 2, jump_EX_i: PC = NORMAL; IF_ID and ID_EX = BUBBLE; EX_MEM and MEM_WB = NORMAL.
REQ-019 Priority 2 also sets the state to DISCARD when if_stall = 1 in the same cycle.
REQ-020 Priority 3, ld_hazard_ID_i: PC and IF_ID = STALL; ID_EX = BUBBLE; EX_MEM and MEM_WB = NORMAL.
REQ-021 Priority 4, if_stall: PC = STALL; IF_ID = BUBBLE; other stages NORMAL.
REQ-022 Otherwise: all stages NORMAL.
REQ-023 Exception to REQ-022: in state DISCARD with if_done_i = 1, IF_ID = BUBBLE.
REQ-024 DISCARD -> RUN on any cycle with if_done_i = 1 and mem_stall = 0, including cycles won by priority 2 or 3; the returned word is dropped.
REQ-025 Simultaneous jump_EX_i and ld_hazard_ID_i resolve as jump (REQ-018).
REQ-026 Simultaneous jump_EX_i and mem_stall resolve as mem_stall; jump_EX_i is held by the stalled EX and takes effect on the release cycle.
REQ-027 A jump while already in DISCARD with if_stall keeps the state DISCARD.
REQ-028 Wait counter (internal, 8 bits minimum): increments each mem_stall cycle and clears on any cycle with mem_stall = 0.
REQ-029 err_o sets on the edge where the wait counter reaches TIMEOUT and holds until reset; pipeline control is unaffected.
REQ-030 stall_cnt_o increments by 1 per cycle with stl_PC_o != NORMAL and holds at all-ones.

Reset
REQ-031 While rst = 0, all five stl_*_o = BUBBLE, independent of clock.
REQ-032 While rst = 0: state RUN; stall_cnt_o = 0; wait counter = 0; err_o = 0.
REQ-033 Reset asserted mid-wait or in DISCARD abandons that state immediately.
REQ-034 The first rising edge after rst returns to 1 evaluates inputs normally.

Verification
REQ-035 Memory wait: mem_req=1, mem_done=0 for 3 cycles, then mem_done=1 -> 3 cycles of PC..EX_MEM=01 and MEM_WB=10, then all 00; stall_cnt_o=3.
REQ-036 Load-use: ld_hazard=1 for 1 cycle -> PC=01, IF_ID=01, ID_EX=10, EX_MEM=00, MEM_WB=00; next cycle all 00.
REQ-037 Jump during fetch: jump=1 and if_req=1, if_done=0 -> PC=00, IF_ID=10, ID_EX=10, state DISCARD; 2 cycles later if_done=1 -> IF_ID=10, state RUN.
REQ-038 Jump plus memory wait: jump=1 and mem_stall for 2 cycles -> MEM priority output; release cycle -> jump pattern of REQ-018.
REQ-039 Timeout: TIMEOUT=4, mem_stall held 6 cycles -> err_o=1 from the 4th edge; remains 1 after mem_done until rst=0.
REQ-040 Async reset: rst=0 mid-stall between edges -> all outputs 10 and stall_cnt_o=0 at once; err_o=0.

Source files
------------

// File: rtl/staller.sv
// Pipeline hazard/stall controller for a 5-stage core.
// In: clk, rst (async, active-low), MEM/IF handshakes, jump, load-use; out: per-stage controls, stall count, timeout flag.
module staller #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_req_MEM_i,
  input  logic             mem_done_i,
  input  logic             jump_EX_i,
  input  logic             ld_hazard_ID_i,
  input  logic             if_req_i,
  input  logic             if_done_i,
  output logic [1:0]       stl_PC_o,
  output logic [1:0]       stl_IF_ID_o,
  output logic [1:0]       stl_ID_EX_o,
  output logic [1:0]       stl_EX_MEM_o,
  output logic [1:0]       stl_MEM_WB_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             err_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int WAIT_W = (TW > 8) ? TW : 8;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  localparam logic [1:0] NORMAL = 2'b00;
  localparam logic [1:0] STALL  = 2'b01;
  localparam logic [1:0] BUBBLE = 2'b10;

  typedef enum logic {RUN, DISCARD} state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic mem_stall, if_stall;
  logic sel_mem, sel_jmp, sel_ld, sel_if, sel_drop;

  assign mem_stall = mem_req_MEM_i & ~mem_done_i;
  assign if_stall  = if_req_i & ~if_done_i;

  // one-hot priority selects
  assign sel_mem  = mem_stall;
  assign sel_jmp  = ~mem_stall & jump_EX_i;
  assign sel_ld   = ~mem_stall & ~jump_EX_i & ld_hazard_ID_i;
  assign sel_if   = ~mem_stall & ~jump_EX_i & ~ld_hazard_ID_i
                  & if_stall;
  // wrong-path fetch returning: drop it
  assign sel_drop = ~mem_stall & ~jump_EX_i & ~ld_hazard_ID_i
                  & ~if_stall & (state_q == DISCARD) & if_done_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // mem_stall freezes the state; a returning fetch always
  // leaves DISCARD, whichever priority owns the cycle
  always_comb begin
    state_d = state_q;
    if (!mem_stall) begin
      if (jump_EX_i & if_stall) state_d = DISCARD;
      else if (if_done_i)       state_d = RUN;
    end
  end

  always_comb begin
    stl_PC_o     = NORMAL;
    stl_IF_ID_o  = NORMAL;
    stl_ID_EX_o  = NORMAL;
    stl_EX_MEM_o = NORMAL;
    stl_MEM_WB_o = NORMAL;
    if (!rst) begin
      stl_PC_o     = BUBBLE;
      stl_IF_ID_o  = BUBBLE;
      stl_ID_EX_o  = BUBBLE;
      stl_EX_MEM_o = BUBBLE;
      stl_MEM_WB_o = BUBBLE;
    end else begin
      unique case (1'b1)
        sel_mem: begin
          stl_PC_o     = STALL;
          stl_IF_ID_o  = STALL;
          stl_ID_EX_o  = STALL;
          stl_EX_MEM_o = STALL;
          stl_MEM_WB_o = BUBBLE;
        end
        sel_jmp: begin
          stl_IF_ID_o = BUBBLE;
          stl_ID_EX_o = BUBBLE;
        end
        sel_ld: begin
          stl_PC_o    = STALL;
          stl_IF_ID_o = STALL;
          stl_ID_EX_o = BUBBLE;
        end
        sel_if: begin
          stl_PC_o    = STALL;
          stl_IF_ID_o = BUBBLE;
        end
        sel_drop: stl_IF_ID_o = BUBBLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    wait_d = '0;
    if (mem_stall)
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
    err_d = err_q | (mem_stall & (wait_d == WAIT_MAX));
    cnt_d = cnt_q;
    if ((stl_PC_o != NORMAL) && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;
  assign err_o       = err_q;

endmodule
